ucsbece154b_icache_prefetch: RTL and testbench

//  Set-associative instruction cache with next-line prefetch into a one-line stream buffer.

---
 rtl/ucsbece154b_icache_prefetch.sv | 164 ++++++++++++++++
 tb/tb_ucsbece154b_icache_prefetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_icache_prefetch.sv
// ucsbece154b_icache_prefetch: set-associative icache with next-line prefetch into a one-line stream buffer
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   readEnable, readAddress         fetch request (~StallF) and PC
//   instruction, ready, busy        fetched word (NOP when not ready), valid flag, fill/prefetch in progress
//   memReadAddress, memReadRequest  block-aligned SDRAM request, held until the first data beat
//   memDataIn, memDataReady         SDRAM burst of BLOCK_WORDS words in order
//   hitCount, missCount, pfHitCount saturating performance counters
module ucsbece154b_icache_prefetch #(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int REPL_MODE   = 0,
  parameter int PREFETCH_EN = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readEnable,
  input  logic [31:0]          readAddress,
  output logic [31:0]          instruction,
  output logic                 ready,
  output logic                 busy,
  output logic [31:0]          memReadAddress,
  output logic                 memReadRequest,
  input  logic [31:0]          memDataIn,
  input  logic                 memDataReady,
  output logic [CNT_WIDTH-1:0] hitCount,
  output logic [CNT_WIDTH-1:0] missCount,
  output logic [CNT_WIDTH-1:0] pfHitCount
);
  localparam int LOG_BW   = $clog2(BLOCK_WORDS);
  localparam int LOG_SETS = $clog2(NUM_SETS);
  localparam int LOG_WAYS = $clog2(NUM_WAYS);
  localparam int WW       = LOG_WAYS > 0 ? LOG_WAYS : 1;
  localparam int BLK_W    = 30 - LOG_BW;
  localparam int TAG_W    = BLK_W - LOG_SETS;

  typedef enum logic [2:0] {LOOKUP, DEM_REQ, DEM_FILL, PF_REQ, PF_FILL, PROMOTE} state_t;
  state_t state;

  logic [NUM_WAYS-1:0] valid [NUM_SETS];
  logic [TAG_W-1:0]    tags  [NUM_SETS][NUM_WAYS];
  logic [31:0]         lines [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [WW-1:0]       rrPtr [NUM_SETS];
  logic [31:0]         bufData  [BLOCK_WORDS];
  logic [31:0]         fillData [BLOCK_WORDS];
  logic [31:0]         lineIn   [BLOCK_WORDS];
  logic                bufValid;
  logic [BLK_W-1:0]    bufBlk, reqBlk, pcBlk, wrBlk, nextBlk;
  logic [LOG_SETS-1:0] pcSet, wSet, nSet;
  logic [TAG_W-1:0]    pcTag, wTag, nTag;
  logic [LOG_BW-1:0]   pcOff, cnt;
  logic [15:0]         lfsr;
  logic [WW-1:0]       hitWay, victim;
  logic hit, nextPresent, bufHit, cacheRd, bufRd, fwd, filling, lastBeat, wrLine, promote;
  logic unusedBits;

  assign pcBlk   = readAddress[31:LOG_BW+2];
  assign pcOff   = readAddress[LOG_BW+1:2];
  assign pcSet   = pcBlk[LOG_SETS-1:0];
  assign pcTag   = pcBlk[BLK_W-1:LOG_SETS];
  assign unusedBits = ^readAddress[1:0];
  assign promote = state == PROMOTE;
  // The line being written is the buffer line during PROMOTE, otherwise the demand line.
  assign wrBlk   = promote ? bufBlk : reqBlk;
  assign wSet    = wrBlk[LOG_SETS-1:0];
  assign wTag    = wrBlk[BLK_W-1:LOG_SETS];
  // Block-number increment wraps, which is the byte address + BLOCK_WORDS*4 modulo 2^32.
  assign nextBlk = wrBlk + 1'b1;
  assign nSet    = nextBlk[LOG_SETS-1:0];
  assign nTag    = nextBlk[BLK_W-1:LOG_SETS];
  assign filling  = memDataReady && state inside {DEM_REQ, DEM_FILL, PF_REQ, PF_FILL};
  assign lastBeat = filling && (&cnt);
  assign wrLine   = promote || (lastBeat && state == DEM_FILL);
  assign bufHit   = bufValid && bufBlk == pcBlk;
  assign cacheRd  = readEnable && hit && state inside {LOOKUP, PF_REQ, PF_FILL, PROMOTE};
  assign bufRd    = readEnable && !hit && bufHit && state == LOOKUP;
  assign fwd      = readEnable && memDataReady && state inside {DEM_REQ, DEM_FILL} && pcBlk == reqBlk && pcOff == cnt;
  assign ready    = cacheRd || bufRd || fwd;
  assign instruction = cacheRd ? lines[pcSet][hitWay][pcOff] : bufRd ? bufData[pcOff] : fwd ? memDataIn : 32'h0000_0013;
  assign busy           = state != LOOKUP;
  assign memReadRequest = state inside {DEM_REQ, PF_REQ};
  assign memReadAddress = {reqBlk, {(LOG_BW+2){1'b0}}};

  always_comb begin
    hit = 1'b0;
    hitWay = '0;
    nextPresent = bufValid && bufBlk == nextBlk;
    victim = NUM_WAYS == 1 ? '0 : REPL_MODE == 1 ? rrPtr[wSet] : lfsr[WW-1:0];
    // Descending scan so the lowest invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[pcSet][w] && tags[pcSet][w] == pcTag) begin
        hit = 1'b1;
        hitWay = WW'(w);
      end
      if (valid[nSet][w] && tags[nSet][w] == nTag) nextPresent = 1'b1;
      if (!valid[wSet][w]) victim = WW'(w);
    end
  end

  always_comb begin
    for (int i = 0; i < BLOCK_WORDS; i++) lineIn[i] = LOG_BW'(i) == cnt ? memDataIn : fillData[i];
  end

  always_ff @(posedge clk) begin
    if (filling) fillData[cnt] <= memDataIn;
    if (wrLine) begin
      tags[wSet][victim] <= wTag;
      for (int i = 0; i < BLOCK_WORDS; i++) lines[wSet][victim][i] <= promote ? bufData[i] : lineIn[i];
    end
    if (lastBeat && state == PF_FILL) bufData <= lineIn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOOKUP;
      valid      <= '{default: '0};
      rrPtr      <= '{default: '0};
      bufValid   <= 1'b0;
      bufBlk     <= '0;
      reqBlk     <= '0;
      cnt        <= '0;
      lfsr       <= 16'hA000;
      hitCount   <= '0;
      missCount  <= '0;
      pfHitCount <= '0;
    end else begin
      if (cacheRd && hitCount != '1) hitCount <= hitCount + 1'b1;
      if (bufRd && pfHitCount != '1) pfHitCount <= pfHitCount + 1'b1;
      if (filling) cnt <= cnt + 1'b1;
      if (wrLine) begin
        valid[wSet][victim] <= 1'b1;
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (NUM_WAYS > 1) rrPtr[wSet] <= rrPtr[wSet] + 1'b1;
      end
      case (state)
        LOOKUP: if (readEnable && !hit) begin
          if (bufHit) state <= PROMOTE;
          else begin
            state  <= DEM_REQ;
            reqBlk <= pcBlk;
            if (missCount != '1) missCount <= missCount + 1'b1;
          end
        end
        DEM_REQ: if (memDataReady) state <= DEM_FILL;
        PF_REQ:  if (memDataReady) state <= PF_FILL;
        DEM_FILL, PROMOTE: if (wrLine) begin
          if (promote) bufValid <= 1'b0;
          if (PREFETCH_EN != 0 && !nextPresent) begin
            state  <= PF_REQ;
            reqBlk <= nextBlk;
          end else state <= LOOKUP;
        end
        PF_FILL: if (lastBeat) begin
          bufValid <= 1'b1;
          bufBlk   <= reqBlk;
          state    <= LOOKUP;
        end
        default: state <= LOOKUP;
      endcase
    end
  end
endmodule

// File: tb/tb_ucsbece154b_icache_prefetch.sv
// tb_ucsbece154b_icache_prefetch: directed self-checking bench for the prefetching icache
module tb_ucsbece154b_icache_prefetch;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset, readEnable, memDataReady;
  logic [31:0] readAddress, memDataIn;
  logic [31:0] instrA, addrA, instrB, addrB;
  logic readyA, busyA, reqA, readyB, busyB, reqB;
  logic [15:0] hitA, missA, pfA;
  logic [3:0] hitB, missB, pfB;
  int compared = 0;
  int mismatched = 0;
  logic rdy [BW];
  logic [31:0] ins [BW];

  always #5 clk = ~clk;

  ucsbece154b_icache_prefetch dutA (
    .clk(clk), .reset(reset), .readEnable(readEnable), .readAddress(readAddress),
    .instruction(instrA), .ready(readyA), .busy(busyA),
    .memReadAddress(addrA), .memReadRequest(reqA),
    .memDataIn(memDataIn), .memDataReady(memDataReady),
    .hitCount(hitA), .missCount(missA), .pfHitCount(pfA)
  );

  ucsbece154b_icache_prefetch #(.REPL_MODE(1), .PREFETCH_EN(0), .CNT_WIDTH(4)) dutB (
    .clk(clk), .reset(reset), .readEnable(readEnable), .readAddress(readAddress),
    .instruction(instrB), .ready(readyB), .busy(busyB),
    .memReadAddress(addrB), .memReadRequest(reqB),
    .memDataIn(memDataIn), .memDataReady(memDataReady),
    .hitCount(hitB), .missCount(missB), .pfHitCount(pfB)
  );

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beats(input logic [31:0] base);
    for (int i = 0; i < BW; i++) begin
      memDataReady = 1'b1;
      memDataIn = mw(base + 32'(4 * i));
      #1;
      rdy[i] = readyA;
      ins[i] = instrA;
      cyc();
    end
    memDataReady = 1'b0;
  endtask

  task automatic demandFill(input logic [31:0] a);
    readEnable = 1'b1;
    readAddress = a;
    cyc();
    readEnable = 1'b0;
    beats(a);
  endtask

  initial begin
    reset = 1'b1;
    readEnable = 1'b0;
    readAddress = '0;
    memDataReady = 1'b0;
    memDataIn = '0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_ready", readyA, 0);
    chk("rst_busy", busyA, 0);
    chk("rst_req", reqA, 0);
    chk("rst_addr", addrA, 0);
    chk("rst_hit", hitA, 0);
    chk("rst_miss", missA, 0);
    chk("rst_pfhit", pfA, 0);
    chk("rst_instr", instrA, 32'h13);

    readEnable = 1'b1;
    readAddress = 32'h100;
    #1;
    chk("t1_miss_ready", readyA, 0);
    chk("t1_miss_instr", instrA, 32'h13);
    cyc();
    #1;
    chk("t1_missCount", missA, 1);
    chk("t1_req", reqA, 1);
    chk("t1_addr", addrA, 32'h100);
    chk("t1_busy", busyA, 1);
    beats(32'h100);
    chk("t1_fwd_ready", rdy[0], 1);
    chk("t1_fwd_instr", ins[0], mw(32'h100));
    chk("t1_beat1_ready", rdy[1], 0);
    readAddress = 32'h104;
    #1;
    chk("t1_hit_ready", readyA, 1);
    chk("t1_hit_instr", instrA, mw(32'h104));
    chk("t2_pf_addr", addrA, 32'h110);
    chk("t2_pf_req", reqA, 1);
    cyc();
    #1;
    chk("t1_hitCount", hitA, 1);
    readEnable = 1'b0;
    beats(32'h110);
    #1;
    chk("t2_pf_done_busy", busyA, 0);
    readEnable = 1'b1;
    readAddress = 32'h118;
    #1;
    chk("t2_buf_ready", readyA, 1);
    chk("t2_buf_instr", instrA, mw(32'h118));
    cyc();
    readEnable = 1'b0;
    #1;
    chk("t2_pfHitCount", pfA, 1);
    chk("t2_promote_busy", busyA, 1);
    chk("t2_missCount", missA, 1);
    cyc();
    #1;
    chk("t2_next_pf_addr", addrA, 32'h120);
    chk("t2_next_pf_req", reqA, 1);
    readEnable = 1'b1;
    readAddress = 32'h114;
    #1;
    chk("t2_promoted_ready", readyA, 1);
    chk("t2_promoted_instr", instrA, mw(32'h114));
    cyc();
    #1;
    chk("t2_hitCount", hitA, 2);

    readAddress = 32'h800;
    #1;
    chk("t4_stall_ready", readyA, 0);
    beats(32'h120);
    for (int i = 0; i < BW; i++) chk("t4_stall_beat", rdy[i], 0);
    #1;
    chk("t4_after_ready", readyA, 0);
    chk("t4_after_busy", busyA, 0);
    chk("t4_after_req", reqA, 0);
    cyc();
    #1;
    chk("t4_dem_addr", addrA, 32'h800);
    chk("t4_dem_req", reqA, 1);
    chk("t4_missCount", missA, 2);

    memDataReady = 1'b1;
    memDataIn = mw(32'h800);
    #1;
    chk("t5_fwd_ready", readyA, 1);
    chk("t5_fwd_instr", instrA, mw(32'h800));
    cyc();
    memDataIn = mw(32'h804);
    #1;
    chk("t5_fill_busy", busyA, 1);
    chk("t5_fill_ready", readyA, 0);
    cyc();
    memDataIn = mw(32'h808);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    memDataIn = mw(32'h80C);
    readAddress = 32'h100;
    #1;
    chk("t5_req", reqA, 0);
    chk("t5_busy", busyA, 0);
    chk("t5_addr", addrA, 0);
    chk("t5_hit", hitA, 0);
    chk("t5_miss", missA, 0);
    chk("t5_pfhit", pfA, 0);
    chk("t5_ready", readyA, 0);
    cyc();
    memDataReady = 1'b0;
    #1;
    chk("t5_next_miss", missA, 1);
    chk("t5_next_addr", addrA, 32'h100);
    chk("t5_next_req", reqA, 1);

    reset = 1'b1;
    readEnable = 1'b0;
    memDataReady = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("b_rst_hit", hitB, 0);
    chk("b_rst_miss", missB, 0);
    chk("b_rst_busy", busyB, 0);
    for (int i = 0; i < 5; i++) demandFill(32'(i * 32'h80));
    #1;
    chk("t3_missCount", missB, 5);
    chk("t3_hitCount", hitB, 0);
    chk("t3_busy", busyB, 0);
    readEnable = 1'b1;
    readAddress = 32'h080;
    #1;
    chk("t3_way1_ready", readyB, 1);
    chk("t3_way1_instr", instrB, mw(32'h080));
    cyc();
    readAddress = 32'h200;
    #1;
    chk("t3_fifth_ready", readyB, 1);
    chk("t3_fifth_instr", instrB, mw(32'h200));
    cyc();
    readAddress = 32'h000;
    #1;
    chk("t3_evicted_ready", readyB, 0);
    cyc();
    #1;
    chk("t3_evicted_miss", missB, 6);
    chk("t3_evicted_busy", busyB, 1);
    readEnable = 1'b0;
    beats(32'h000);
    readEnable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      readAddress = 32'(4 * (i % 4));
      #1;
      chk("t6_hit_ready", readyB, 1);
      cyc();
    end
    #1;
    chk("t6_saturated", hitB, 4'hF);
    readAddress = 32'h080;
    #1;
    chk("t6_rr_evict_ready", readyB, 0);
    readAddress = 32'h100;
    #1;
    chk("t6_way2_ready", readyB, 1);
    chk("t6_way2_instr", instrB, mw(32'h100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
